// File: rtl/victim_write_buffer_pkg.sv
// Shared types for the victim write buffer: FSM states, buffered-line entry
// layout and the line-offset constant.
package victim_wb_types;

  localparam int OFFSET         = 4;
  localparam int WB_ADDR_W      = 16;
  localparam int WB_LINE_W      = 128;
  localparam int WB_LINE_ADDR_W = WB_ADDR_W - OFFSET;

  typedef enum logic [1:0] {
    IDLE,
    RD_MEM,
    DRAIN,
    RESP
  } state_t;

  typedef struct packed {
    logic                      valid;
    logic [WB_LINE_ADDR_W-1:0] line_addr;
    logic [WB_LINE_W-1:0]      data;
  } entry_t;

endpackage

// File: rtl/victim_write_buffer_if.sv
// Bundle of the upstream (victim cache) and downstream (L2) buses of the
// write buffer. The buffer is the slave; the environment is the master.
interface victim_write_buffer_if
  import victim_wb_types::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int LINE_W = WB_LINE_W
);

  logic              up_read;
  logic              up_write;
  logic [ADDR_W-1:0] up_addr;
  logic [LINE_W-1:0] up_wdata;
  logic [LINE_W-1:0] up_rdata;
  logic              up_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  up_read, up_write, up_addr, up_wdata, mem_rdata, mem_resp,
    output up_rdata, up_resp, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output up_read, up_write, up_addr, up_wdata, mem_rdata, mem_resp,
    input  up_rdata, up_resp, mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/victim_write_buffer_entry_array.sv
// Circular store of buffered dirty lines with head/tail pointers, an
// occupancy count, and a combinational line-address match.
module wb_entry_array
  import victim_wb_types::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [WB_LINE_ADDR_W-1:0] push_line,
  input  logic [WB_LINE_W-1:0]      write_data,
  input  logic                      coalesce,
  input  logic [PTR_W-1:0]          coalesce_idx,
  input  logic                      pop,
  input  logic [WB_LINE_ADDR_W-1:0] lookup_line,
  output logic                      hit,
  output logic [PTR_W-1:0]          hit_idx,
  output logic [WB_LINE_W-1:0]      hit_data,
  output logic [WB_LINE_ADDR_W-1:0] head_line,
  output logic [WB_LINE_W-1:0]      head_data,
  output logic [PTR_W:0]            count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  entry_t            entries [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              do_push;
  logic              do_pop;

  assign do_push   = push && (count != FULL_COUNT);
  assign do_pop    = pop && (count != '0);
  assign hit_data  = entries[hit_idx].data;
  assign head_line = entries[head].line_addr;
  assign head_data = entries[head].data;

  // Writes coalesce, so at most one valid entry can ever match a line.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].valid && (entries[i].line_addr == lookup_line)) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        entries[tail] <= '{valid: 1'b1, line_addr: push_line, data: write_data};
        tail          <= tail + PTR_W'(1);
      end
      if (coalesce) begin
        entries[coalesce_idx].data <= write_data;
      end
      if (do_pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (PTR_W+1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/victim_write_buffer.sv
// Write-back buffer between the victim cache and L2: absorbs evicted dirty
// lines, serves read hits locally, and drains lines to L2 in FIFO order.
module victim_write_buffer
  import victim_wb_types::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int LINE_W = WB_LINE_W,
  parameter int DEPTH  = 2
) (
  input logic                  clk,
  input logic                  reset,
  victim_write_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);

  state_t                     state;
  logic                       up_resp_q;
  logic                       mem_read_q;
  logic                       mem_write_q;
  logic [ADDR_W-1:0]          mem_addr_q;
  logic [LINE_W-1:0]          mem_wdata_q;
  logic [LINE_W-1:0]          up_rdata_q;

  logic [ADDR_W-OFFSET-1:0]   up_line;
  logic [ADDR_W-OFFSET-1:0]   head_line;
  logic [LINE_W-1:0]          hit_data;
  logic [LINE_W-1:0]          head_data;
  logic                       hit;
  logic [PTR_W-1:0]           hit_idx;
  logic [PTR_W:0]             count;
  logic                       full;
  logic                       empty;
  logic                       push;
  logic                       coalesce;
  logic                       pop;
  logic                       unused_addr_bits;

  assign up_line  = bus.up_addr[ADDR_W-1:OFFSET];
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign coalesce = (state == IDLE) && bus.up_write && hit;
  assign push     = (state == IDLE) && bus.up_write && !hit && !full;
  assign pop      = (state == DRAIN) && bus.mem_resp;

  // Byte offset within a line plays no part in buffering or matching.
  assign unused_addr_bits = ^bus.up_addr[OFFSET-1:0];

  assign bus.up_resp   = up_resp_q;
  assign bus.up_rdata  = up_rdata_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  wb_entry_array #(.DEPTH(DEPTH)) u_entries (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .push_line    (up_line),
    .write_data   (bus.up_wdata),
    .coalesce     (coalesce),
    .coalesce_idx (hit_idx),
    .pop          (pop),
    .lookup_line  (up_line),
    .hit          (hit),
    .hit_idx      (hit_idx),
    .hit_data     (hit_data),
    .head_line    (head_line),
    .head_data    (head_data),
    .count        (count)
  );

  // Writes beat reads; a write to a full buffer first drains the head line
  // and then re-evaluates in IDLE. An L2 transaction always runs to mem_resp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      up_resp_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      up_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.up_write) begin
            if (hit || !full) begin
              up_resp_q <= 1'b1;
              state     <= RESP;
            end else begin
              mem_write_q <= 1'b1;
              mem_addr_q  <= {head_line, {OFFSET{1'b0}}};
              mem_wdata_q <= head_data;
              state       <= DRAIN;
            end
          end else if (bus.up_read) begin
            if (hit) begin
              up_rdata_q <= hit_data;
              up_resp_q  <= 1'b1;
              state      <= RESP;
            end else begin
              mem_read_q <= 1'b1;
              mem_addr_q <= {up_line, {OFFSET{1'b0}}};
              state      <= RD_MEM;
            end
          end else if (!empty) begin
            mem_write_q <= 1'b1;
            mem_addr_q  <= {head_line, {OFFSET{1'b0}}};
            mem_wdata_q <= head_data;
            state       <= DRAIN;
          end
        end
        RD_MEM: begin
          if (bus.mem_resp) begin
            up_rdata_q <= bus.mem_rdata;
            up_resp_q  <= 1'b1;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
            state      <= RESP;
          end
        end
        DRAIN: begin
          if (bus.mem_resp) begin
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            state       <= IDLE;
          end
        end
        RESP: begin
          up_resp_q <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
